// File: rtl/memory_arbiter.sv
// memory_arbiter: N-channel round-robin arbiter onto one memory port, one transaction in flight.
// Define MEMORY_ARBITER_BOUNDS_CHECK_EN to reject out-of-range or misaligned requests locally.
module memory_arbiter #(
  parameter int NUM_CHANNELS   = 3,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int MEM_SIZE_BYTES = 65536
) (
  input  logic                                 clock,
  input  logic                                 clear_n,
  input  logic [NUM_CHANNELS-1:0]              ch_req_valid,
  input  logic [NUM_CHANNELS*ADDR_WIDTH-1:0]   ch_req_address,
  input  logic [NUM_CHANNELS-1:0]              ch_req_write,
  input  logic [NUM_CHANNELS*DATA_WIDTH-1:0]   ch_req_write_data,
  output logic [NUM_CHANNELS-1:0]              ch_req_ready,
  output logic [NUM_CHANNELS-1:0]              ch_rsp_valid,
  output logic                                 ch_rsp_error,
  output logic [DATA_WIDTH-1:0]                ch_rsp_read_data,
  input  logic [NUM_CHANNELS-1:0]              ch_rsp_ready,
  output logic                                 mem_req_valid,
  output logic [ADDR_WIDTH-1:0]                mem_req_address,
  output logic                                 mem_req_write,
  output logic [DATA_WIDTH-1:0]                mem_req_write_data,
  input  logic                                 mem_req_ready,
  input  logic                                 mem_rsp_valid,
  input  logic                                 mem_rsp_error,
  input  logic [DATA_WIDTH-1:0]                mem_rsp_read_data,
  output logic                                 busy,
  output logic [$clog2(NUM_CHANNELS)-1:0]      grant_id
);
  localparam int GW    = $clog2(NUM_CHANNELS);
  localparam int BYTES = DATA_WIDTH / 8;
`ifdef MEMORY_ARBITER_BOUNDS_CHECK_EN
  localparam bit BOUNDS_CHECK = 1'b1;
`else
  localparam bit BOUNDS_CHECK = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESPOND} state_t;

  state_t                  r_state;
  logic [GW-1:0]           r_rr_ptr;
  logic [GW-1:0]           r_grant_id;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic                    r_write;
  logic [DATA_WIDTH-1:0]   r_wdata;
  logic                    r_mem_valid;
  logic [NUM_CHANNELS-1:0] r_rsp_valid;
  logic                    r_rsp_error;
  logic [DATA_WIDTH-1:0]   r_rsp_data;

  logic [GW-1:0]           w_grant;
  logic [GW-1:0]           w_next_ptr;
  logic                    w_any;
  logic                    w_reject;
  logic [ADDR_WIDTH-1:0]   w_addr;
  logic [NUM_CHANNELS-1:0] w_grant_oh;

  function automatic logic [GW-1:0] rr_idx(input logic [GW-1:0] base, input int k);
    int j;
    j = int'(base) + k;
    return GW'(j >= NUM_CHANNELS ? j - NUM_CHANNELS : j);
  endfunction

  // Scan from the farthest offset down so the channel nearest rr_ptr wins.
  always_comb begin
    w_any   = 1'b0;
    w_grant = '0;
    for (int k = NUM_CHANNELS - 1; k >= 0; k--) begin
      if (ch_req_valid[rr_idx(r_rr_ptr, k)]) begin
        w_any   = 1'b1;
        w_grant = rr_idx(r_rr_ptr, k);
      end
    end
  end

  assign w_next_ptr = (w_grant == GW'(NUM_CHANNELS - 1)) ? '0 : w_grant + 1'b1;
  assign w_addr     = ch_req_address[w_grant*ADDR_WIDTH +: ADDR_WIDTH];
  assign w_grant_oh = NUM_CHANNELS'(1) << w_grant;
  assign w_reject   = BOUNDS_CHECK && ((64'(w_addr) >= 64'(MEM_SIZE_BYTES)) ||
                                       ((w_addr & ADDR_WIDTH'(BYTES - 1)) != '0));

  assign ch_req_ready       = (r_state == IDLE && w_any) ? w_grant_oh : '0;
  assign ch_rsp_valid       = r_rsp_valid;
  assign ch_rsp_error       = r_rsp_error;
  assign ch_rsp_read_data   = r_rsp_data;
  assign mem_req_valid      = r_mem_valid;
  assign mem_req_address    = r_addr;
  assign mem_req_write      = r_write;
  assign mem_req_write_data = r_wdata;
  assign busy               = r_state != IDLE;
  assign grant_id           = r_grant_id;

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      r_state     <= IDLE;
      r_rr_ptr    <= '0;
      r_grant_id  <= '0;
      r_addr      <= '0;
      r_write     <= 1'b0;
      r_wdata     <= '0;
      r_mem_valid <= 1'b0;
      r_rsp_valid <= '0;
      r_rsp_error <= 1'b0;
      r_rsp_data  <= '0;
    end else begin
      case (r_state)
        IDLE: if (w_any) begin
          r_grant_id  <= w_grant;
          r_rr_ptr    <= w_next_ptr;
          r_addr      <= w_addr;
          r_write     <= ch_req_write[w_grant];
          r_wdata     <= ch_req_write_data[w_grant*DATA_WIDTH +: DATA_WIDTH];
          r_rsp_error <= w_reject;
          r_rsp_data  <= '0;
          r_rsp_valid <= w_reject ? w_grant_oh : '0;
          r_mem_valid <= !w_reject;
          r_state     <= w_reject ? RESPOND : ISSUE;
        end
        ISSUE: if (mem_req_ready) begin
          r_mem_valid <= 1'b0;
          r_state     <= WAIT;
        end
        WAIT: if (mem_rsp_valid) begin
          r_rsp_error <= mem_rsp_error;
          r_rsp_data  <= r_write ? '0 : mem_rsp_read_data;
          r_rsp_valid <= NUM_CHANNELS'(1) << r_grant_id;
          r_state     <= RESPOND;
        end
        RESPOND: if (ch_rsp_ready[r_grant_id]) begin
          r_rsp_valid <= '0;
          r_state     <= IDLE;
        end
      endcase
    end
  end
endmodule
